// File: rtl/mem_resp.sv
`default_nettype none
// ============================================================================
// Module   : mem_resp
// Purpose  : Single-outstanding data-memory responder. Accepts one load or
//            store over a valid/ready request channel, waits a fixed access
//            latency, commits the store or reads the addressed word from a
//            local word-addressed array, then presents read data and an
//            error flag on a valid/ready response channel.
// Ports    : clk, rst (async, active-high)
//            req_valid/req_ready            request handshake
//            req_wen, req_addr, req_wdata,  request payload (store when
//            req_wmask                      req_wen=1, byte enables in wmask)
//            rsp_valid/rsp_ready            response handshake
//            rsp_rdata, rsp_err             load data (0 for stores/errors),
//                                           access-fault flag
// Revision : 1.0 - initial release
// ============================================================================
module mem_resp #(
    parameter int                   ISA_WIDTH = 32,
    parameter int                   DEPTH     = 1024,
    parameter logic [ISA_WIDTH-1:0] BASE      = 32'h8000_0000,
    parameter int                   LATENCY   = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_wen,
    input  logic [ISA_WIDTH-1:0]   req_addr,
    input  logic [ISA_WIDTH-1:0]   req_wdata,
    input  logic [ISA_WIDTH/8-1:0] req_wmask,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [ISA_WIDTH-1:0]   rsp_rdata,
    output logic                   rsp_err
);

    localparam int c_NB = ISA_WIDTH / 8;
    localparam int c_IW = $clog2(DEPTH);
    // Counter only ever holds values up to LATENCY-1.
    localparam int c_CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [c_CW-1:0]      c_CNT_LOAD = c_CW'(LATENCY - 1);
    localparam logic [ISA_WIDTH-1:0] c_SPAN     = ISA_WIDTH'(DEPTH * 4);
    localparam logic                 c_DIRECT   = (LATENCY == 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [c_CW-1:0]        r_cnt;
    logic                   r_wen;
    logic [ISA_WIDTH-1:0]   r_addr;
    logic [ISA_WIDTH-1:0]   r_wdata;
    logic [c_NB-1:0]        r_wmask;
    logic [ISA_WIDTH-1:0]   r_rdata;
    logic                   r_err;
    logic [ISA_WIDTH-1:0]   r_mem [DEPTH];

    logic                   w_accept;
    logic                   w_commit;
    logic                   w_op_wen;
    logic [ISA_WIDTH-1:0]   w_op_addr;
    logic [ISA_WIDTH-1:0]   w_op_wdata;
    logic [c_NB-1:0]        w_op_wmask;
    logic [ISA_WIDTH-1:0]   w_offset;
    logic                   w_err;
    logic [c_IW-1:0]        w_idx;

    assign w_accept = req_valid && (r_state == S_IDLE);

    // With a latency of one the commit edge is the acceptance edge, so the
    // operation has to come straight from the request inputs; otherwise it
    // comes from the registers captured at acceptance.
    assign w_op_wen   = (r_state == S_IDLE) ? req_wen   : r_wen;
    assign w_op_addr  = (r_state == S_IDLE) ? req_addr  : r_addr;
    assign w_op_wdata = (r_state == S_IDLE) ? req_wdata : r_wdata;
    assign w_op_wmask = (r_state == S_IDLE) ? req_wmask : r_wmask;

    // Offset wraps modulo 2^ISA_WIDTH, so addresses below BASE become huge
    // offsets and fall into the out-of-range check.
    assign w_offset = w_op_addr - BASE;
    assign w_err    = (w_offset[1:0] != 2'b00) || (w_offset >= c_SPAN);
    assign w_idx    = w_offset[c_IW+1:2];

    always_comb begin
        w_state_nxt = r_state;
        w_commit    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (req_valid) begin
                    if (c_DIRECT) begin
                        w_state_nxt = S_RESP;
                        w_commit    = 1'b1;
                    end else begin
                        w_state_nxt = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (r_cnt == c_CW'(1)) begin
                    w_state_nxt = S_RESP;
                    w_commit    = 1'b1;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Datapath and array. The array has no reset value; it sits in the
    // reset domain only so that a write can never land while rst is high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt   <= '0;
            r_wen   <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_wmask <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_wen   <= req_wen;
                r_addr  <= req_addr;
                r_wdata <= req_wdata;
                r_wmask <= req_wmask;
                r_cnt   <= c_CNT_LOAD;
            end else if (r_state == S_WAIT) begin
                r_cnt <= r_cnt - c_CW'(1);
            end

            if (w_commit) begin
                r_err   <= w_err;
                r_rdata <= (w_err || w_op_wen) ? '0 : r_mem[w_idx];
                if (!w_err && w_op_wen) begin
                    for (int i = 0; i < c_NB; i++) begin
                        if (w_op_wmask[i]) begin
                            r_mem[w_idx][i*8 +: 8] <= w_op_wdata[i*8 +: 8];
                        end
                    end
                end
            end else if ((r_state == S_RESP) && rsp_ready) begin
                r_rdata <= '0;
                r_err   <= 1'b0;
            end
        end
    end

    assign req_ready = (r_state == S_IDLE);
    assign rsp_valid = (r_state == S_RESP);
    assign rsp_rdata = r_rdata;
    assign rsp_err   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_mem_resp.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_resp
// Purpose  : Self-checking bench for mem_resp. Four instances run side by
//            side with LATENCY = 1..4 (DEPTH = 16). A transaction-level model
//            of each instance (array contents, busy flag, cycles to response)
//            is checked against the DUT outputs every cycle, and directed
//            literal expectations pin the model on known cases.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_resp;

    localparam int          NI    = 4;
    localparam int          DEP   = 16;
    localparam logic [31:0] BASE  = 32'h8000_0000;

    logic        clk;
    logic        rst       [NI];
    logic        req_valid [NI];
    logic        req_ready [NI];
    logic        req_wen   [NI];
    logic [31:0] req_addr  [NI];
    logic [31:0] req_wdata [NI];
    logic [3:0]  req_wmask [NI];
    logic        rsp_valid [NI];
    logic        rsp_ready [NI];
    logic [31:0] rsp_rdata [NI];
    logic        rsp_err   [NI];

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    bit done  [NI];

    for (genvar j = 0; j < NI; j++) begin : g_dut
        mem_resp #(
            .ISA_WIDTH(32),
            .DEPTH    (DEP),
            .BASE     (BASE),
            .LATENCY  (j + 1)
        ) u_dut (
            .clk      (clk),
            .rst      (rst[j]),
            .req_valid(req_valid[j]),
            .req_ready(req_ready[j]),
            .req_wen  (req_wen[j]),
            .req_addr (req_addr[j]),
            .req_wdata(req_wdata[j]),
            .req_wmask(req_wmask[j]),
            .rsp_valid(rsp_valid[j]),
            .rsp_ready(rsp_ready[j]),
            .rsp_rdata(rsp_rdata[j]),
            .rsp_err  (rsp_err[j])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] mem_m   [NI][DEP];
    bit          m_busy  [NI];
    int          m_wait  [NI];   // edges left until the response is visible
    logic        m_wen   [NI];
    logic [31:0] m_addr  [NI];
    logic [31:0] m_wdata [NI];
    logic [3:0]  m_wmask [NI];
    logic [31:0] m_rdata [NI];
    logic        m_err   [NI];

    function automatic void commit(input int k);
        logic [31:0] off;
        logic [31:0] w;
        int          idx;
        off = m_addr[k] - BASE;
        if ((off % 4) != 0 || off >= 32'(DEP * 4)) begin
            m_err[k]   = 1'b1;
            m_rdata[k] = 32'h0;
        end else begin
            idx      = int'(off / 4);
            m_err[k] = 1'b0;
            if (m_wen[k]) begin
                w = mem_m[k][idx];
                for (int b = 0; b < 4; b++)
                    if (m_wmask[k][b]) w[b*8 +: 8] = m_wdata[k][b*8 +: 8];
                mem_m[k][idx] = w;
                m_rdata[k]    = 32'h0;
            end else begin
                m_rdata[k] = mem_m[k][idx];
            end
        end
    endfunction

    // Single compare process: check outputs against the model, then advance
    // the model across the coming rising edge using the current inputs.
    always @(negedge clk) begin
        for (int k = 0; k < NI; k++) begin
            if (rst[k]) begin
                chk("rst_req_ready", 32'(req_ready[k]), 32'd1);
                chk("rst_rsp_valid", 32'(rsp_valid[k]), 32'd0);
                chk("rst_rsp_rdata", rsp_rdata[k], 32'd0);
                chk("rst_rsp_err",   32'(rsp_err[k]),   32'd0);
                m_busy[k] = 1'b0;
                m_wait[k] = 0;
            end else begin
                chk("req_ready", 32'(req_ready[k]), 32'(!m_busy[k]));
                chk("rsp_valid", 32'(rsp_valid[k]), 32'(m_busy[k] && m_wait[k] == 0));
                if (m_busy[k] && m_wait[k] == 0) begin
                    chk("rsp_rdata", rsp_rdata[k], m_rdata[k]);
                    chk("rsp_err",   32'(rsp_err[k]), 32'(m_err[k]));
                end
                if (!m_busy[k]) begin
                    if (req_valid[k]) begin
                        m_busy[k]  = 1'b1;
                        m_wen[k]   = req_wen[k];
                        m_addr[k]  = req_addr[k];
                        m_wdata[k] = req_wdata[k];
                        m_wmask[k] = req_wmask[k];
                        m_wait[k]  = k;          // LATENCY-1
                        if (m_wait[k] == 0) commit(k);
                    end
                end else if (m_wait[k] > 0) begin
                    m_wait[k]--;
                    if (m_wait[k] == 0) commit(k);
                end else if (rsp_ready[k]) begin
                    m_busy[k] = 1'b0;
                end
            end
        end
    end

    // ---------------- drivers ----------------
    // Called at posedge+1. mode 0: rsp_ready=1; 1: random rsp_ready and
    // stray req_valid pulses; 2: hold rsp_ready=0 for 5 valid cycles with
    // stray req_valid pulses and stability checks.
    task automatic do_req(input int k, input logic wen, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] wmask, input int mode,
                          output logic [31:0] rd, output logic er);
        bit acc = 0, fin = 0, seen = 0;
        int lat = 0, nval = 0;
        rd = 32'h0; er = 1'b0;
        req_wen[k] = wen; req_addr[k] = addr; req_wdata[k] = wdata; req_wmask[k] = wmask;
        req_valid[k] = 1'b1;
        for (int c = 0; c < 50 && !acc; c++) begin
            @(negedge clk);
            if (req_ready[k]) acc = 1;
            @(posedge clk); #1;
        end
        req_valid[k] = 1'b0;
        req_addr[k]  = $urandom; req_wdata[k] = $urandom;
        chk("accept_seen", 32'(acc), 32'd1);
        for (int c = 0; c < 60 && acc && !fin; c++) begin
            case (mode)
                0:       rsp_ready[k] = 1'b1;
                1:       rsp_ready[k] = 1'($urandom_range(0, 1));
                default: rsp_ready[k] = (nval >= 5);
            endcase
            if (mode != 0) req_valid[k] = ($urandom_range(0, 2) == 0);
            @(negedge clk);
            if (rsp_valid[k]) begin
                nval++;
                if (!seen) begin
                    seen = 1; lat = c + 1; rd = rsp_rdata[k]; er = rsp_err[k];
                end else if (mode == 2) begin
                    chk("stall_rdata", rsp_rdata[k], rd);
                    chk("stall_err", 32'(rsp_err[k]), 32'(er));
                    chk("stall_req_ready", 32'(req_ready[k]), 32'd0);
                end
                if (rsp_ready[k]) fin = 1;
            end
            @(posedge clk); #1;
        end
        req_valid[k] = 1'b0;
        rsp_ready[k] = 1'b0;
        chk("rsp_handshake", 32'(fin), 32'd1);
        chk("latency", 32'(lat), 32'(k + 1));
        if (mode == 2) chk("stall_cycles", 32'(nval), 32'd6);
    endtask

    task automatic b2b(input int k);
        int acc_cyc [3];
        int n = 0;
        req_wen[k] = 1'b0; req_addr[k] = BASE + 32'(4 * $urandom_range(0, DEP - 1));
        req_valid[k] = 1'b1; rsp_ready[k] = 1'b1;
        for (int c = 0; c < 60 && n < 3; c++) begin
            @(negedge clk);
            if (req_ready[k]) begin acc_cyc[n] = cyc; n++; end
            @(posedge clk); #1;
        end
        req_valid[k] = 1'b0;
        chk("b2b_accepts", 32'(n), 32'd3);
        if (n == 3) begin
            chk("b2b_gap1", 32'(acc_cyc[1] - acc_cyc[0]), 32'(k + 2));
            chk("b2b_gap2", 32'(acc_cyc[2] - acc_cyc[1]), 32'(k + 2));
        end
        repeat (k + 4) @(posedge clk);
        #1;
        rsp_ready[k] = 1'b0;
    endtask

    task automatic run_inst(input int k);
        logic [31:0] rd, a;
        logic        er;
        int          sel;
        chk("post_rst_req_ready", 32'(req_ready[k]), 32'd1);
        chk("post_rst_rsp_valid", 32'(rsp_valid[k]), 32'd0);
        for (int w = 0; w < DEP; w++)
            do_req(k, 1'b1, BASE + 32'(4 * w), $urandom, 4'hF, 0, rd, er);

        if (k == 1) begin
            do_req(k, 1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 0, rd, er);
            chk("st_err", 32'(er), 32'd0);
            chk("st_rdata", rd, 32'h0);
            do_req(k, 1'b0, 32'h8000_0010, 32'h0, 4'h0, 0, rd, er);
            chk("ld_deadbeef", rd, 32'hDEAD_BEEF);
            do_req(k, 1'b1, 32'h8000_0010, 32'h1122_3344, 4'b0101, 0, rd, er);
            do_req(k, 1'b0, 32'h8000_0010, 32'h0, 4'h0, 0, rd, er);
            chk("ld_masked", rd, 32'hDE22_BE44);
            do_req(k, 1'b0, 32'h8000_0002, 32'h0, 4'h0, 0, rd, er);
            chk("misalign_err", 32'(er), 32'd1);
            chk("misalign_rdata", rd, 32'h0);
            do_req(k, 1'b1, BASE + 32'(4 * (DEP - 1)), 32'hCAFE_F00D, 4'hF, 0, rd, er);
            do_req(k, 1'b1, BASE + 32'(4 * DEP), 32'h5555_AAAA, 4'hF, 0, rd, er);
            chk("oor_err", 32'(er), 32'd1);
            do_req(k, 1'b0, BASE + 32'(4 * (DEP - 1)), 32'h0, 4'h0, 0, rd, er);
            chk("last_word_kept", rd, 32'hCAFE_F00D);
            do_req(k, 1'b0, 32'h7FFF_FFFC, 32'h0, 4'h0, 0, rd, er);
            chk("below_base_err", 32'(er), 32'd1);
            do_req(k, 1'b0, 32'h8000_0010, 32'h0, 4'h0, 2, rd, er);
            chk("stall_ld", rd, 32'hDE22_BE44);
            do_req(k, 1'b1, 32'h8000_0010, 32'hFFFF_FFFF, 4'h0, 0, rd, er);
            chk("zero_mask_err", 32'(er), 32'd0);
            do_req(k, 1'b0, 32'h8000_0010, 32'h0, 4'h0, 0, rd, er);
            chk("zero_mask_ld", rd, 32'hDE22_BE44);
        end

        if (k == 2) begin
            do_req(k, 1'b1, BASE + 32'd32, 32'h0BAD_F00D, 4'hF, 0, rd, er);
            req_wen[k] = 1'b1; req_addr[k] = BASE + 32'd32;
            req_wdata[k] = 32'h1234_5678; req_wmask[k] = 4'hF; req_valid[k] = 1'b1;
            @(negedge clk);
            chk("rst_test_ready", 32'(req_ready[k]), 32'd1);
            @(posedge clk); #1;
            req_valid[k] = 1'b0;
            @(posedge clk); #2;
            rst[k] = 1'b1;
            #1;
            chk("async_rst_req_ready", 32'(req_ready[k]), 32'd1);
            chk("async_rst_rsp_valid", 32'(rsp_valid[k]), 32'd0);
            chk("async_rst_rsp_rdata", rsp_rdata[k], 32'h0);
            chk("async_rst_rsp_err", 32'(rsp_err[k]), 32'd0);
            @(posedge clk);
            @(negedge clk); #1;
            rst[k] = 1'b0;
            @(posedge clk); #1;
            do_req(k, 1'b0, BASE + 32'd32, 32'h0, 4'h0, 0, rd, er);
            chk("rst_dropped_store", rd, 32'h0BAD_F00D);
        end

        b2b(k);

        for (int n = 0; n < 50; n++) begin
            sel = $urandom_range(0, 9);
            if (sel < 7)       a = BASE + 32'(4 * $urandom_range(0, DEP - 1));
            else if (sel == 7) a = BASE + 32'(4 * $urandom_range(0, DEP - 1) + $urandom_range(1, 3));
            else if (sel == 8) a = BASE + 32'(4 * DEP) + 32'(4 * $urandom_range(0, 100));
            else               a = BASE - 32'(4 * $urandom_range(1, 1000));
            do_req(k, 1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)), 1, rd, er);
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        end
        done[k] = 1'b1;
    endtask

    function automatic bit all_done();
        bit r = 1;
        for (int k = 0; k < NI; k++) r &= done[k];
        return r;
    endfunction

    initial begin
        for (int k = 0; k < NI; k++) begin
            rst[k] = 1'b1; req_valid[k] = 1'b0; req_wen[k] = 1'b0;
            req_addr[k] = '0; req_wdata[k] = '0; req_wmask[k] = '0;
            rsp_ready[k] = 1'b0; done[k] = 1'b0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        for (int k = 0; k < NI; k++) rst[k] = 1'b0;
        @(posedge clk); #1;
        fork
            run_inst(0);
            run_inst(1);
            run_inst(2);
            run_inst(3);
        join_none
        for (int c = 0; c < 20000 && !all_done(); c++) @(posedge clk);
        chk("all_instances_done", 32'(all_done()), 32'd1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
